// File: rtl/rv32c_fetch_aligner_if.sv
// ---------------------------------------------------------------------------
// rv32c_fetch_aligner_if
//   Bundles the signals of the RV32C fetch aligner:
//     redirect_en / redirect_pc            - flush and restart from execute
//     imem_req / imem_addr                 - word-aligned read request
//     imem_ack / imem_rdata                - read completion and data
//     out_valid / out_ready                - instruction handshake
//     out_inst / out_pc / out_compressed   - delivered instruction
//   master: the aligner itself.  slave: memory plus downstream stage.
// ---------------------------------------------------------------------------
interface rv32c_fetch_aligner_if;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_compressed;

    modport master (
        input  redirect_en, redirect_pc,
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output out_valid, out_inst, out_pc, out_compressed,
        input  out_ready
    );

    modport slave (
        output redirect_en, redirect_pc,
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  out_valid, out_inst, out_pc, out_compressed,
        output out_ready
    );
endinterface

// File: rtl/rv32c_fetch_aligner.sv
// ---------------------------------------------------------------------------
// rv32c_fetch_aligner
//   Fetches 32-bit words from instruction memory, queues them as 16-bit
//   halfwords and hands out one naturally aligned instruction (compressed or
//   32-bit, possibly straddling a word boundary) per handshake with its PC.
//
//   Ports:
//     clk   - clock
//     nrst  - synchronous, active-high reset
//     bus   - rv32c_fetch_aligner_if.master (redirect, imem, output handshake)
//
//   Parameters:
//     RESET_PC - first instruction PC after reset (bit 1 may be set)
//     HQ_DEPTH - halfword queue entries, even and >= 4
//
//   Build option:
//     FETCH_ALIGNER_BYPASS_EN - when defined, an instruction completed by the
//     first usable half of an ack into an empty queue is presented
//     combinationally in the ack cycle (and not queued if accepted).
// ---------------------------------------------------------------------------
module rv32c_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          HQ_DEPTH = 6
) (
    input  logic                  clk,
    input  logic                  nrst,
    rv32c_fetch_aligner_if.master bus
);
    localparam int PW = $clog2(HQ_DEPTH);
    localparam int CW = $clog2(HQ_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t        state;
    logic [15:0]   hq [HQ_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fetch_addr;    // address of the outstanding/next read
    logic [31:0]   head_pc;       // PC of the queue head
    logic          drop_low;      // next ack starts at its upper half
    logic          imem_req_q;
    logic [31:0]   imem_addr_q;
    logic          out_valid_q, out_compressed_q;
    logic [31:0]   out_inst_q;

    // Circular increment for a queue depth that need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p, input logic [1:0] inc);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(inc);
        if (s >= (PW+1)'(HQ_DEPTH)) s = s - (PW+1)'(HQ_DEPTH);
        return s[PW-1:0];
    endfunction

    logic          ack_take, pop;
    logic [1:0]    pop_n, n_cand, n_byp, n_push, pc_adv;
    logic [15:0]   cand0, cand1, push0, push1, e0, e1;
    logic          byp_valid, byp_comp;
    logic [31:0]   byp_inst;
    logic [CW-1:0] remain, count_next;
    logic [PW-1:0] rd_next;
    logic          room;
    logic          nxt_valid, nxt_comp;
    logic [31:0]   nxt_inst;

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        ack_take  = (state == WAIT) && bus.imem_ack && !bus.redirect_en;
        pop       = out_valid_q && bus.out_ready && !bus.redirect_en;
        pop_n     = out_compressed_q ? 2'd1 : 2'd2;

        // Usable halves of the returned word, in address order.
        if (drop_low) begin
            cand0  = bus.imem_rdata[31:16];
            cand1  = bus.imem_rdata[31:16];
            n_cand = 2'd1;
        end else begin
            cand0  = bus.imem_rdata[15:0];
            cand1  = bus.imem_rdata[31:16];
            n_cand = 2'd2;
        end

        byp_valid = 1'b0;
        byp_comp  = 1'b0;
        byp_inst  = 32'h0;
        n_byp     = 2'd0;
`ifdef FETCH_ALIGNER_BYPASS_EN
        if (ack_take && count == '0) begin
            if (cand0[1:0] != 2'b11) begin
                byp_valid = 1'b1;
                byp_comp  = 1'b1;
                byp_inst  = {16'h0, cand0};
            end else if (!drop_low) begin
                byp_valid = 1'b1;
                byp_inst  = bus.imem_rdata;
            end
            if (byp_valid && bus.out_ready) n_byp = byp_comp ? 2'd1 : 2'd2;
        end
`else
        // Outputs come only from the registered queue head.
`endif

        // Halves consumed by the bypass are skipped; the rest are queued.
        n_push = ack_take ? (n_cand - n_byp) : 2'd0;
        push0  = (n_byp == 2'd1) ? cand1 : cand0;
        push1  = cand1;

        remain     = count - (pop ? CW'(pop_n) : CW'(0));
        rd_next    = pop ? wrap_inc(rd_ptr, pop_n) : rd_ptr;
        count_next = remain + CW'(n_push);
        room       = count_next <= CW'(HQ_DEPTH - 2);

        // Post-push/pop head entries feed the registered outputs, giving
        // one-cycle latency from ack to out_valid.
        e0 = (remain >= CW'(1)) ? hq[rd_next] : push0;
        if (remain >= CW'(2))      e1 = hq[wrap_inc(rd_next, 2'd1)];
        else if (remain == CW'(1)) e1 = push0;
        else                       e1 = push1;

        nxt_comp  = (e0[1:0] != 2'b11);
        nxt_valid = (count_next >= CW'(2)) || (count_next == CW'(1) && nxt_comp);
        nxt_inst  = nxt_comp ? {16'h0, e0} : {e1, e0};

        pc_adv = pop ? pop_n : n_byp;
    end

    // NOTE: the halfword storage is not reset; count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) hq[wr_ptr] <= push0;
        if (n_push == 2'd2) hq[wrap_inc(wr_ptr, 2'd1)] <= push1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state            <= IDLE;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            fetch_addr       <= {RESET_PC[31:2], 2'b00};
            head_pc          <= RESET_PC;
            drop_low         <= RESET_PC[1];
            imem_req_q       <= 1'b0;
            imem_addr_q      <= {RESET_PC[31:2], 2'b00};
            out_valid_q      <= 1'b0;
            out_compressed_q <= 1'b0;
            out_inst_q       <= 32'h0;
        end else if (bus.redirect_en) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            head_pc     <= {bus.redirect_pc[31:1], 1'b0};
            fetch_addr  <= {bus.redirect_pc[31:2], 2'b00};
            drop_low    <= bus.redirect_pc[1];
            out_valid_q <= 1'b0;
            // An in-flight read must still complete; its data is stale.
            if (state != IDLE) begin
                if (bus.imem_ack) begin
                    state      <= IDLE;
                    imem_req_q <= 1'b0;
                end else begin
                    state <= DISCARD;
                end
            end
        end else begin
            wr_ptr           <= wrap_inc(wr_ptr, n_push);
            rd_ptr           <= rd_next;
            count            <= count_next;
            head_pc          <= head_pc + {29'h0, pc_adv, 1'b0};
            out_valid_q      <= nxt_valid;
            out_compressed_q <= nxt_comp;
            out_inst_q       <= nxt_inst;
            case (state)
                IDLE: begin
                    if (room) begin
                        state       <= WAIT;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_addr;
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        drop_low   <= 1'b0;
                        fetch_addr <= fetch_addr + 32'd4;
                        if (room) begin
                            imem_addr_q <= fetch_addr + 32'd4;
                        end else begin
                            state      <= IDLE;
                            imem_req_q <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        state      <= IDLE;
                        imem_req_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_req       = imem_req_q;
    assign bus.imem_addr      = imem_addr_q;
    assign bus.out_valid      = out_valid_q | byp_valid;
    assign bus.out_inst       = byp_valid ? byp_inst : out_inst_q;
    assign bus.out_compressed = byp_valid ? byp_comp : out_compressed_q;
    assign bus.out_pc         = head_pc;

    // Halfword PCs make redirect_pc[0] meaningless.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = bus.redirect_pc[0];
endmodule

// File: tb/tb_rv32c_fetch_aligner.sv
// ---------------------------------------------------------------------------
// tb_rv32c_fetch_aligner
//   Directed self-checking bench for rv32c_fetch_aligner (RESET_PC=80000000,
//   HQ_DEPTH=6). Inputs change 1 time unit after the rising edge; outputs are
//   sampled 1 time unit after that.
// ---------------------------------------------------------------------------
module tb_rv32c_fetch_aligner;
`ifdef FETCH_ALIGNER_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic nrst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    rv32c_fetch_aligner_if bus ();

    rv32c_fetch_aligner #(
        .RESET_PC (32'h8000_0000),
        .HQ_DEPTH (6)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.out_ready   = 1'b0;
    endtask

    // Leaves the DUT in WAIT with a read of 80000000 outstanding.
    task automatic do_reset(input string tag);
        idle_inputs();
        nrst = 1'b1;
        step();
        step();
        settle();
        check({tag, "_rst_req"}, {31'h0, bus.imem_req}, 32'h0);
        check({tag, "_rst_valid"}, {31'h0, bus.out_valid}, 32'h0);
        nrst = 1'b0;
        step();
        settle();
        check({tag, "_first_req"}, {31'h0, bus.imem_req}, 32'h1);
        check({tag, "_first_addr"}, bus.imem_addr, 32'h8000_0000);
    endtask

    logic [31:0] words [3];
    logic [31:0] exp_inst [5];
    logic [31:0] exp_pc [5];
    logic        exp_comp [5];

    initial begin
        words[0] = 32'h00A0_0513;
        words[1] = 32'h4605_4585;
        words[2] = 32'h0001_8082;
        exp_inst[0] = 32'h00A0_0513; exp_pc[0] = 32'h8000_0000; exp_comp[0] = 1'b0;
        exp_inst[1] = 32'h0000_4585; exp_pc[1] = 32'h8000_0004; exp_comp[1] = 1'b1;
        exp_inst[2] = 32'h0000_4605; exp_pc[2] = 32'h8000_0006; exp_comp[2] = 1'b1;
        exp_inst[3] = 32'h0000_8082; exp_pc[3] = 32'h8000_0008; exp_comp[3] = 1'b1;
        exp_inst[4] = 32'h0000_0001; exp_pc[4] = 32'h8000_000A; exp_comp[4] = 1'b1;

        // ---- 32-bit aligned instruction ----
        do_reset("t1");
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0001_0113;
        settle();
        check("t1_ack_cycle_valid", {31'h0, bus.out_valid}, {31'h0, BYP});
        step();
        bus.imem_ack = 1'b0;
        settle();
        check("t1_valid", {31'h0, bus.out_valid}, 32'h1);
        check("t1_inst", bus.out_inst, 32'h0001_0113);
        check("t1_pc", bus.out_pc, 32'h8000_0000);
        check("t1_comp", {31'h0, bus.out_compressed}, 32'h0);
        check("t1_next_addr", bus.imem_addr, 32'h8000_0004);
        check("t1_next_req", {31'h0, bus.imem_req}, 32'h1);
        step();
        settle();
        check("t1_hold_valid", {31'h0, bus.out_valid}, 32'h1);
        check("t1_hold_inst", bus.out_inst, 32'h0001_0113);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        settle();
        check("t1_pop_valid", {31'h0, bus.out_valid}, 32'h0);
        check("t1_pop_pc", bus.out_pc, 32'h8000_0004);

        // ---- two compressed instructions in one word ----
        do_reset("t2");
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4501_0505;
        settle();
        check("t2_ack_cycle_valid", {31'h0, bus.out_valid}, {31'h0, BYP});
        step();
        bus.imem_ack = 1'b0;
        settle();
        check("t2_c0_valid", {31'h0, bus.out_valid}, 32'h1);
        check("t2_c0_inst", bus.out_inst, 32'h0000_0505);
        check("t2_c0_pc", bus.out_pc, 32'h8000_0000);
        check("t2_c0_comp", {31'h0, bus.out_compressed}, 32'h1);
        bus.out_ready = 1'b1;
        step();
        settle();
        check("t2_c1_valid", {31'h0, bus.out_valid}, 32'h1);
        check("t2_c1_inst", bus.out_inst, 32'h0000_4501);
        check("t2_c1_pc", bus.out_pc, 32'h8000_0002);
        step();
        bus.out_ready = 1'b0;
        settle();
        check("t2_empty_valid", {31'h0, bus.out_valid}, 32'h0);

        // ---- 32-bit instruction straddling a word boundary ----
        do_reset("t3");
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0113_4505;
        step();
        bus.imem_ack = 1'b0;
        settle();
        check("t3_c_inst", bus.out_inst, 32'h0000_4505);
        check("t3_c_pc", bus.out_pc, 32'h8000_0000);
        check("t3_next_addr", bus.imem_addr, 32'h8000_0004);
        bus.out_ready = 1'b1;
        step();
        settle();
        check("t3_half_valid", {31'h0, bus.out_valid}, 32'h0);
        check("t3_half_pc", bus.out_pc, 32'h8000_0002);
        step();
        settle();
        check("t3_still_half", {31'h0, bus.out_valid}, 32'h0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hABCD_0001;
        settle();
        check("t3_ack2_cycle_valid", {31'h0, bus.out_valid}, 32'h0);
        step();
        bus.imem_ack = 1'b0; bus.out_ready = 1'b0;
        settle();
        check("t3_w_valid", {31'h0, bus.out_valid}, 32'h1);
        check("t3_w_inst", bus.out_inst, 32'h0001_0113);
        check("t3_w_pc", bus.out_pc, 32'h8000_0002);
        check("t3_w_comp", {31'h0, bus.out_compressed}, 32'h0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        settle();
        check("t3_after_pc", bus.out_pc, 32'h8000_0006);
        check("t3_after_inst", bus.out_inst, 32'h0000_ABCD);

        // ---- redirect with a read outstanding ----
        do_reset("t4");
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h8000_0102;
        step();
        bus.redirect_en = 1'b0;
        settle();
        check("t4_disc_req", {31'h0, bus.imem_req}, 32'h1);
        check("t4_disc_addr", bus.imem_addr, 32'h8000_0000);
        check("t4_disc_valid", {31'h0, bus.out_valid}, 32'h0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        settle();
        check("t4_stale_valid", {31'h0, bus.out_valid}, 32'h0);
        step();
        bus.imem_ack = 1'b0;
        settle();
        check("t4_idle_req", {31'h0, bus.imem_req}, 32'h0);
        check("t4_idle_valid", {31'h0, bus.out_valid}, 32'h0);
        step();
        settle();
        check("t4_new_req", {31'h0, bus.imem_req}, 32'h1);
        check("t4_new_addr", bus.imem_addr, 32'h8000_0100);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4581_1111;
        settle();
        check("t4_ack_cycle_valid", {31'h0, bus.out_valid}, {31'h0, BYP});
        step();
        bus.imem_ack = 1'b0;
        settle();
        check("t4_first_valid", {31'h0, bus.out_valid}, 32'h1);
        check("t4_first_inst", bus.out_inst, 32'h0000_4581);
        check("t4_first_pc", bus.out_pc, 32'h8000_0102);
        // Pop offered in the redirect cycle must be ignored.
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h8000_0200; bus.out_ready = 1'b1;
        step();
        bus.redirect_en = 1'b0; bus.out_ready = 1'b0;
        settle();
        check("t4_redir2_valid", {31'h0, bus.out_valid}, 32'h0);
        check("t4_redir2_pc", bus.out_pc, 32'h8000_0200);
        check("t4_redir2_addr", bus.imem_addr, 32'h8000_0104);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
        step();
        bus.imem_ack = 1'b0;
        step();
        settle();
        check("t4_redir2_new_addr", bus.imem_addr, 32'h8000_0200);

        // ---- backpressure: acks while the consumer stalls ----
        do_reset("t5");
        begin
            int n_acks = 0;
            for (int i = 0; i < 10; i++) begin
                bus.imem_ack   = bus.imem_req;
                bus.imem_rdata = (n_acks < 3) ? words[n_acks] : 32'h0;
                if (bus.imem_req) n_acks++;
                step();
            end
            bus.imem_ack = 1'b0;
            settle();
            check("t5_acks_taken", n_acks, 32'd3);
            check("t5_req_stopped", {31'h0, bus.imem_req}, 32'h0);
            check("t5_hold_valid", {31'h0, bus.out_valid}, 32'h1);
            check("t5_hold_inst", bus.out_inst, 32'h00A0_0513);
        end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            settle();
            check($sformatf("t5_drain%0d_valid", j), {31'h0, bus.out_valid}, 32'h1);
            check($sformatf("t5_drain%0d_inst", j), bus.out_inst, exp_inst[j]);
            check($sformatf("t5_drain%0d_pc", j), bus.out_pc, exp_pc[j]);
            check($sformatf("t5_drain%0d_comp", j), {31'h0, bus.out_compressed}, {31'h0, exp_comp[j]});
            step();
        end
        bus.out_ready = 1'b0;
        settle();
        check("t5_drained_valid", {31'h0, bus.out_valid}, 32'h0);
        check("t5_resume_req", {31'h0, bus.imem_req}, 32'h1);
        check("t5_resume_addr", bus.imem_addr, 32'h8000_000C);

        // ---- ack into an empty queue with the consumer ready ----
        do_reset("t6");
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0013; bus.out_ready = 1'b1;
        settle();
        check("t6_ack_cycle_valid", {31'h0, bus.out_valid}, {31'h0, BYP});
        if (BYP) begin
            check("t6_byp_inst", bus.out_inst, 32'h0000_0013);
            check("t6_byp_pc", bus.out_pc, 32'h8000_0000);
            step();
            bus.imem_ack = 1'b0;
            settle();
            check("t6_byp_after_valid", {31'h0, bus.out_valid}, 32'h0);
            check("t6_byp_after_pc", bus.out_pc, 32'h8000_0004);
        end else begin
            step();
            bus.imem_ack = 1'b0;
            settle();
            check("t6_reg_valid", {31'h0, bus.out_valid}, 32'h1);
            check("t6_reg_inst", bus.out_inst, 32'h0000_0013);
            check("t6_reg_pc", bus.out_pc, 32'h8000_0000);
            step();
            settle();
            check("t6_reg_after_valid", {31'h0, bus.out_valid}, 32'h0);
            check("t6_reg_after_pc", bus.out_pc, 32'h8000_0004);
        end
        bus.out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv32c_fetch_aligner.md
Name: rv32c_fetch_aligner

Overview:
- Sits directly upstream of the compressed-instruction fetch buffer/decompressor stage.
- Issues word-aligned instruction-memory reads and queues the returned data as 16-bit halfwords.
- Delivers one naturally aligned instruction per handshake with its PC and a compressed flag; 32-bit instructions may straddle a word boundary.
- Flushes on PC redirect from execute.

Parameters:
- RESET_PC, 32'h80000000, first instruction PC after reset; bit 1 may be set.
- HQ_DEPTH, 6, halfword queue entries; must be even and >= 4.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-high
- redirect_en  in  1  flush queue and restart at redirect_pc
- redirect_pc  in  32  new PC; bit 0 ignored
- imem_req  out  1  read request
- imem_addr  out  32  word-aligned read address, bits [1:0] = 0
- imem_ack  in  1  read complete; data valid this cycle
- imem_rdata  in  32  read data; little-endian, lower half at lower address
- out_valid  out  1  out_inst/out_pc/out_compressed valid
- out_ready  in  1  downstream accepts
- out_inst  out  32  instruction; when compressed, [31:16] = 0
- out_pc  out  32  PC of out_inst
- out_compressed  out  1  1 when out_inst[1:0] != 2'b11

Behaviour:
- Reset (nrst=1 at a clk edge):
  - queue empty; out_valid=0; imem_req=0; state=IDLE.
  - fetch_addr = {RESET_PC[31:2], 2'b00}; head_pc = RESET_PC; drop_low = RESET_PC[1].
  - Reset mid-request abandons the request; the next ack is ignored only if it arrives while in IDLE (bench must not ack after reset).
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE -> WAIT when free entries >= 2 and redirect_en=0. In that cycle imem_req=1 and imem_addr=fetch_addr (registered output, asserted from the next cycle).
  - WAIT: imem_req and imem_addr held stable until imem_ack.
    - On ack: push lower half unless drop_low, then upper half. Clear drop_low; fetch_addr += 4.
    - Next state: WAIT with a new address if free entries after push/pop are >= 2, else IDLE.
  - WAIT + redirect_en without ack -> DISCARD. Request stays asserted with the old address.
  - DISCARD + ack -> data dropped -> IDLE.
  - DISCARD + redirect_en: fetch_addr/drop_low updated again; stays DISCARD.
- Redirect:
  - Same cycle: queue flushed; head_pc = {redirect_pc[31:1], 0}; fetch_addr = {redirect_pc[31:2], 00}; drop_low = redirect_pc[1].
  - out_valid=0 in the cycle after redirect.
  - An ack in the redirect cycle is discarded.
  - A pop in the redirect cycle is ignored.
- Output (registered from queue head):
  - head[1:0] != 11 and count >= 1 -> valid compressed.
  - head[1:0] == 11 and count >= 2 -> valid 32-bit, {entry1, entry0}.
  - A 32-bit instruction with only one half queued holds out_valid=0 until its upper half arrives.
- Handshake:
  - out_valid && out_ready pops 1 or 2 entries; head_pc += 2 or 4 (modulo 2^32, wraps FFFFFFFE -> 0).
  - out_valid holds and outputs stay stable while out_ready=0.
- Push and pop in the same cycle are legal. Free-entry check uses post-pop count; never overflows.
- Baseline latency: ack at cycle N -> out_valid at N+1 when the queue was empty.

Optional Feature:
- Macro: FETCH_ALIGNER_BYPASS_EN.
- Defined: when the queue is empty, state=WAIT, imem_ack=1, and the first usable half forms a complete instruction (compressed, or 32-bit with drop_low=0):
  - out_valid, out_inst, out_pc and out_compressed are driven combinationally from imem_rdata in the ack cycle.
  - If out_ready=1, that instruction is not pushed.
  - Residual halves are pushed as normal.
- Undefined: one-cycle baseline latency; outputs purely registered.

Test Plan:
- Reset RESET_PC=80000000, ack word 00010113 -> out_valid, out_inst=00010113, out_pc=80000000, out_compressed=0; next imem_addr=80000004.
- Ack word 4501_0505 -> two compressed outputs 0505 @80000000 then 4501 @80000002; out_inst[31:16]=0.
- Straddle: words 0113_4505, then xxxx_0001 -> 4505 @80000000; 00010113 @80000002 valid only after second ack; head_pc then 80000006.
- Redirect to 80000102 while WAIT outstanding -> stale ack dropped; next imem_addr=80000100; lower half discarded; first out_pc=80000102.
- out_ready=0 for 10 cycles with continuous acks -> imem_req stops once free entries < 2; no entry lost; outputs stable; drains in order.
- BYPASS_EN: empty queue, ack 00000013 with out_ready=1 -> out_valid same cycle, out_pc=80000000; undefined build -> out_valid one cycle later.
